regfile_access_ctrl: RTL

- Sits between the core datapath and regfile. Shares regfile write port and read port 2 between three requesters: core writeback, a debug/host access port, and a register-clear sequencer.
- The core always has priority. Debug and clear operations use idle slots only.
- Debug accesses use a valid/ready request handshake and a valid/ready response handshake.

---
 rtl/rfac_pkg.sv | 17 +
 rtl/regfile_access_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rfac_pkg.sv
// rfac_pkg: shared types and constants for the regfile access controller.
//   rfac_state_t : controller FSM states
//   REG_IDX_W    : width of a register index
//   REG_X0       : index of the hardwired-zero register
package rfac_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DBG_WAIT = 2'd1,
        DBG_RSP  = 2'd2,
        CLEAR    = 2'd3
    } rfac_state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
//   Shares the regfile write port and read port 2 between core writeback
//   (always highest priority), a debug/host access port and a register-clear
//   sequencer. Debug and clear operations only use slots the core leaves idle.
//
// Ports
//   clk, reset_n (async, active-low)
//   core_we/core_rd/core_wd      : core writeback request
//   core_rs2/core_rs2_en         : core read port 2 request
//   rf_we/rf_rd/rf_wd            : regfile write port
//   rf_rs2/rf_rd2                : regfile read port 2 (rf_rd2 combinational)
//   dbg_req_*                    : debug request, valid/ready
//   dbg_rsp_*                    : debug response, valid/ready
//   clear_req/clear_busy/clear_done : clear sequencer control/status
//   core_stall                   : asks the core to free a slot
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The sender holds valid and payload stable until then; the
// response payload (dbg_rsp_rdata) is stable for as long as dbg_rsp_valid.
//
// Optional feature macro: RFAC_STALL_EN. When defined, a blocked-cycle
// counter drives core_stall; otherwise core_stall is tied low.
//
// The FSM state is visible for debug as the internal signal state_q.
module regfile_access_ctrl
    import rfac_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NREGS        = 32,
    parameter int STALL_THRESH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 core_we,
    input  logic [REG_IDX_W-1:0] core_rd,
    input  logic [XLEN-1:0]      core_wd,
    input  logic [REG_IDX_W-1:0] core_rs2,
    input  logic                 core_rs2_en,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_rd,
    output logic [XLEN-1:0]      rf_wd,
    output logic [REG_IDX_W-1:0] rf_rs2,
    input  logic [XLEN-1:0]      rf_rd2,
    input  logic                 dbg_req_valid,
    output logic                 dbg_req_ready,
    input  logic                 dbg_req_write,
    input  logic [REG_IDX_W-1:0] dbg_req_addr,
    input  logic [XLEN-1:0]      dbg_req_wdata,
    output logic                 dbg_rsp_valid,
    input  logic                 dbg_rsp_ready,
    output logic [XLEN-1:0]      dbg_rsp_rdata,
    input  logic                 clear_req,
    output logic                 clear_busy,
    output logic                 clear_done,
    output logic                 core_stall
);

    localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NREGS - 1);

    rfac_state_t          state_q, state_d;
    logic [REG_IDX_W-1:0] idx_q, idx_d;
    logic                 pend_write_q;
    logic [REG_IDX_W-1:0] pend_addr_q;
    logic [XLEN-1:0]      pend_wdata_q;
    logic [XLEN-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic                 clear_done_q, clear_done_d;

    logic wr_slot_free;
    logic rd_slot_free;
    logic req_fire;

    assign wr_slot_free = !core_we || (core_rd == REG_X0);
    assign rd_slot_free = !core_rs2_en;

    // clear_req takes precedence over a simultaneous debug request.
    assign dbg_req_ready = (state_q == IDLE) && !clear_req;
    assign req_fire      = dbg_req_valid && dbg_req_ready;

    assign dbg_rsp_valid = (state_q == DBG_RSP);
    assign dbg_rsp_rdata = rsp_rdata_q;
    assign clear_busy    = (state_q == CLEAR);
    assign clear_done    = clear_done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            pend_write_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            rsp_rdata_q  <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rsp_rdata_q  <= rsp_rdata_d;
            clear_done_q <= clear_done_d;
            if (req_fire) begin
                pend_write_q <= dbg_req_write;
                pend_addr_q  <= dbg_req_addr;
                pend_wdata_q <= dbg_req_wdata;
            end
        end
    end

    // Next state plus port mux. The core passthrough is the default and is
    // only overridden when the slot it would need is idle.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rsp_rdata_d  = rsp_rdata_q;
        clear_done_d = 1'b0;
        rf_we        = core_we && (core_rd != REG_X0);
        rf_rd        = core_rd;
        rf_wd        = core_wd;
        rf_rs2       = core_rs2;

        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    idx_d   = REG_IDX_W'(1);
                end else if (req_fire) begin
                    state_d = DBG_WAIT;
                end
            end

            DBG_WAIT: begin
                if (pend_write_q) begin
                    if (pend_addr_q == REG_X0) begin
                        // x0 is hardwired; complete without touching the port.
                        state_d     = DBG_RSP;
                        rsp_rdata_d = '0;
                    end else if (wr_slot_free) begin
                        rf_we       = 1'b1;
                        rf_rd       = pend_addr_q;
                        rf_wd       = pend_wdata_q;
                        state_d     = DBG_RSP;
                        rsp_rdata_d = '0;
                    end
                end else if (rd_slot_free) begin
                    rf_rs2      = pend_addr_q;
                    rsp_rdata_d = rf_rd2;
                    state_d     = DBG_RSP;
                end
            end

            DBG_RSP: begin
                if (dbg_rsp_ready) begin
                    state_d = IDLE;
                end
            end

            CLEAR: begin
                if (wr_slot_free) begin
                    rf_we = 1'b1;
                    rf_rd = idx_q;
                    rf_wd = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d      = IDLE;
                        clear_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + REG_IDX_W'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

`ifdef RFAC_STALL_EN
    localparam int CNT_W = $clog2(STALL_THRESH + 1);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(STALL_THRESH);

    logic             slot_blocked;
    logic [CNT_W-1:0] blk_cnt_q;

    // The slot the pending operation needs is held by the core this cycle.
    assign slot_blocked =
        ((state_q == DBG_WAIT) &&
         ((pend_write_q && (pend_addr_q != REG_X0) && !wr_slot_free) ||
          (!pend_write_q && !rd_slot_free))) ||
        ((state_q == CLEAR) && !wr_slot_free);

    // Any cycle that is not blocked either uses the slot or is a different
    // state, so the counter simply clears whenever blocking stops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_cnt_q <= '0;
        end else if (slot_blocked && (state_d == state_q)) begin
            if (blk_cnt_q != THRESH) begin
                blk_cnt_q <= blk_cnt_q + CNT_W'(1);
            end
        end else begin
            blk_cnt_q <= '0;
        end
    end

    assign core_stall = (blk_cnt_q == THRESH);
`else
    assign core_stall = 1'b0;
`endif

endmodule
